// File: rtl/and_2in_unit_edge_counter.sv
// rtl/and_2in_unit_edge_counter.sv - rise/fall pulse detector with saturating rise counter
module and_2in_unit_edge_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               rise,
    output logic               fall,
    output logic [COUNT_W-1:0] rise_cnt
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            rise_cnt <= '0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
            fall <= ~din & prev;
            // clear wins over a same-cycle increment; counter sticks at max
            if (cnt_clr) begin
                rise_cnt <= '0;
            end else if (rise && (rise_cnt != CNT_MAX)) begin
                rise_cnt <= rise_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/and_2in_unit.sv
// rtl/and_2in_unit.sv - bitwise 2-input AND with registered, edge-detected, counted copy
module and_2in_unit #(
    parameter int WIDTH   = 1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   Y,
    output logic [WIDTH-1:0]   y_q,
    output logic               rise,
    output logic               fall,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] rise_cnt
);

    // Y is pure logic: independent of clk and rst_n
    assign Y = A & B;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= Y;
        end
    end

    and_2in_unit_edge_counter #(
        .COUNT_W (COUNT_W)
    ) u_edge_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (y_q[0]),
        .cnt_clr  (cnt_clr),
        .rise     (rise),
        .fall     (fall),
        .rise_cnt (rise_cnt)
    );

endmodule

// File: tb/tb_and_2in_unit.sv
// tb/tb_and_2in_unit.sv - scoreboard bench for and_2in_unit (1-bit/16-bit and 8-bit/2-bit builds)
module tb_and_2in_unit;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n;
    logic        cnt_clr;
    logic        a1, b1;
    logic [7:0]  a8, b8;

    logic        y1, yq1, rise1, fall1;
    logic [15:0] cnt1;
    logic [7:0]  y8, yq8;
    logic        rise8, fall8;
    logic [1:0]  cnt8;

    int n_cmp = 0;
    int n_bad = 0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    and_2in_unit #(.WIDTH(1), .COUNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Y(y1), .y_q(yq1),
        .rise(rise1), .fall(fall1), .cnt_clr(cnt_clr), .rise_cnt(cnt1)
    );

    and_2in_unit #(.WIDTH(8), .COUNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Y(y8), .y_q(yq8),
        .rise(rise8), .fall(fall8), .cnt_clr(cnt_clr), .rise_cnt(cnt8)
    );

    typedef struct {
        logic        yq1;
        logic        r1, f1;
        logic [15:0] c1;
        logic [7:0]  yq8;
        logic        r8, f8;
        logic [1:0]  c8;
    } exp_t;

    exp_t sbq[$];

    // reference: history of y_q values since reset, rises counted since last clear
    logic [7:0] hist1[$];
    logic [7:0] hist8[$];
    int         n_r1, n_r8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic exp_t model_edge(input logic ia1, input logic ib1, input logic [7:0] ia8,
                                        input logic [7:0] ib8, input logic clr, input logic rst);
        exp_t e;
        int   s;
        if (!rst) begin
            hist1 = '{8'd0, 8'd0, 8'd0};
            hist8 = '{8'd0, 8'd0, 8'd0};
            n_r1 = 0;
            n_r8 = 0;
            e.r1 = 0; e.f1 = 0; e.r8 = 0; e.f8 = 0;
        end else begin
            s = hist1.size();
            // rise pulse present before this edge: value two edges ago went 0->1
            if (clr) n_r1 = 0; else n_r1 += (hist1[s-2][0] && !hist1[s-3][0]) ? 1 : 0;
            if (clr) n_r8 = 0; else n_r8 += (hist8[s-2][0] && !hist8[s-3][0]) ? 1 : 0;
            e.r1 = hist1[s-1][0] && !hist1[s-2][0];
            e.f1 = !hist1[s-1][0] && hist1[s-2][0];
            e.r8 = hist8[s-1][0] && !hist8[s-2][0];
            e.f8 = !hist8[s-1][0] && hist8[s-2][0];
            hist1.push_back({7'd0, ia1 & ib1});
            hist8.push_back(ia8 & ib8);
            void'(hist1.pop_front());
            void'(hist8.pop_front());
        end
        e.yq1 = hist1[hist1.size()-1][0];
        e.yq8 = hist8[hist8.size()-1];
        e.c1  = 16'(sat(n_r1, 65535));
        e.c8  = 2'(sat(n_r8, 3));
        return e;
    endfunction

    // drive inputs just after an edge, check Y combinationally, then model the next edge
    task automatic step(input logic ia1, input logic ib1, input logic [7:0] ia8,
                        input logic [7:0] ib8, input logic clr, input logic rst);
        exp_t e;
        a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8; cnt_clr = clr; rst_n = rst;
        #1;
        chk("Y1", 32'(y1), 32'(ia1 & ib1));
        chk("Y8", 32'(y8), 32'(ia8 & ib8));
        @(posedge clk);
        e = model_edge(ia1, ib1, ia8, ib8, clr, rst);
        sbq.push_back(e);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("yq1",  32'(yq1),   32'(e.yq1));
                chk("rise1", 32'(rise1), 32'(e.r1));
                chk("fall1", 32'(fall1), 32'(e.f1));
                chk("cnt1", 32'(cnt1),  32'(e.c1));
                chk("yq8",  32'(yq8),   32'(e.yq8));
                chk("rise8", 32'(rise8), 32'(e.r8));
                chk("fall8", 32'(fall8), 32'(e.f8));
                chk("cnt8", 32'(cnt8),  32'(e.c8));
            end
        end
    end

    initial begin : stim
        logic [1:0] ab;
        rst_n = 1'b1; cnt_clr = 1'b0;
        a1 = 0; b1 = 0; a8 = 0; b8 = 0;
        // clock idle: truth table on the combinational path
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[0]; b1 = ab[1];
            a8 = {8{ab[0]}}; b8 = {8{ab[1]}};
            #20;
            chk("idle_Y1", 32'(y1), (i == 3) ? 32'd1 : 32'd0);
            chk("idle_Y8", 32'(y8), (i == 3) ? 32'hFF : 32'd0);
        end
        // reset held: Y tracks inputs, registers held at zero
        rst_n = 1'b0; a1 = 1; b1 = 1; a8 = 8'hF0; b8 = 8'h3C;
        #1;
        chk("rst_Y1", 32'(y1), 32'd1);
        chk("rst_Y8", 32'(y8), 32'h30);
        chk("rst_yq1", 32'(yq1), 32'd0);
        chk("rst_rise1", 32'(rise1), 32'd0);
        chk("rst_fall1", 32'(fall1), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_cnt8", 32'(cnt8), 32'd0);
        clk_en = 1'b1;
        @(posedge clk); #1;
        step(1, 1, 8'hFF, 8'hFF, 0, 0);
        step(1, 1, 8'hFF, 8'hFF, 0, 0);
        // release: A=B=1 sampled at first edge, rise one edge later, count one more
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        chk("rel_yq1", 32'(yq1), 32'd1);
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        chk("rel_rise1", 32'(rise1), 32'd1);
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        chk("rel_cnt1", 32'(cnt1), 32'd1);
        // toggle A 1->0->1
        step(0, 1, 8'h00, 8'hFF, 0, 1);
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        step(1, 1, 8'hFF, 8'hFF, 0, 1);
        chk("tog_cnt1", 32'(cnt1), 32'd2);
        // five rises into the 2-bit counter
        step(0, 1, 8'h00, 8'hFF, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 8'h01, 8'hFF, 0, 1);
            step(0, 1, 8'h00, 8'hFF, 0, 1);
        end
        step(0, 1, 8'h00, 8'hFF, 0, 1);
        step(0, 1, 8'h00, 8'hFF, 0, 1);
        chk("sat_cnt8", 32'(cnt8), 32'd3);
        chk("sat_cnt1", 32'(cnt1), 32'd5);
        // clear coincident with a rise pulse
        step(1, 1, 8'h01, 8'hFF, 0, 1);
        step(1, 1, 8'h01, 8'hFF, 0, 1);
        chk("clr_rise1", 32'(rise1), 32'd1);
        step(1, 1, 8'h01, 8'hFF, 1, 1);
        chk("clr_cnt1", 32'(cnt1), 32'd0);
        chk("clr_cnt8", 32'(cnt8), 32'd0);
        // 8-bit pattern
        step(0, 0, 8'hF0, 8'h3C, 0, 1);
        chk("w8_yq", 32'(yq8), 32'h30);
        // randomized traffic with one asynchronous reset mid-run
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(negedge clk); #1;
                rst_n = 1'b0;
                #1;
                chk("async_yq8", 32'(yq8), 32'd0);
                chk("async_cnt1", 32'(cnt1), 32'd0);
                chk("async_rise1", 32'(rise1), 32'd0);
                void'(model_edge(0, 0, 8'h00, 8'h00, 0, 0));
                @(posedge clk); #1;
                step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 0, 0);
            end
            step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0), 1);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
